fwft_fifo_sync: RTL and testbench

// Single-clock, first-word-fall-through (FWFT) FIFO. It is the synchronous stand-in for
// xpm_fifo_async, used beneath the HAL FIFO wrapper in simulation and in single-clock builds.
// It keeps the xpm port set (full, prog_full, almost_full, counts, overflow/underflow, reset-busy)
// and uses read latency 0.

---
 rtl/fwft_fifo_sync.sv | 152 +++++++++++++++
 tb/tb_fwft_fifo_sync.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_fifo_sync.sv
// Single-clock first-word-fall-through FIFO with an xpm_fifo-style flag and count set.
// Latency: write visible on dout one cycle after acceptance; flags/counts registered from next-state count.
// Backpressure: writes dropped while full (overflow pulse), reads dropped while empty (underflow pulse).
module fwft_fifo_sync #(
    parameter int FIFO_DEPTH        = 16,
    parameter int DATA_WIDTH        = 32,
    parameter int COUNT_WIDTH       = 5,
    parameter int PROG_FULL_THRESH  = 11,
    parameter int PROG_EMPTY_THRESH = 5,
    parameter int FULL_RESET_VALUE  = 1,
    parameter int RST_BUSY_CYCLES   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic                   full,
    output logic                   almost_full,
    output logic                   prog_full,
    output logic [COUNT_WIDTH-1:0] wr_data_count,
    output logic                   overflow,
    output logic                   wr_ack,
    output logic                   wr_rst_busy,
    input  logic                   rd_en,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   empty,
    output logic                   almost_empty,
    output logic                   prog_empty,
    output logic [COUNT_WIDTH-1:0] rd_data_count,
    output logic                   underflow,
    output logic                   data_valid,
    output logic                   rd_rst_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [COUNT_WIDTH-1:0] FULL_C   = COUNT_WIDTH'(FIFO_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] AFULL_C  = COUNT_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] PFULL_C  = COUNT_WIDTH'(PROG_FULL_THRESH);
    localparam logic [COUNT_WIDTH-1:0] PEMPTY_C = COUNT_WIDTH'(PROG_EMPTY_THRESH);
    localparam logic [COUNT_WIDTH-1:0] ONE_C    = COUNT_WIDTH'(1);
    localparam logic [3:0]             BUSY_C   = 4'(RST_BUSY_CYCLES);
    localparam logic                   FULL_RST = (FULL_RESET_VALUE != 0);

    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

    logic [PW-1:0]          wptr_q, wptr_d;
    logic [PW-1:0]          rptr_q, rptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [3:0]             busy_cnt_q, busy_cnt_d;

    logic full_q, full_d;
    logic afull_q, afull_d;
    logic pfull_q, pfull_d;
    logic empty_q, empty_d;
    logic aempty_q, aempty_d;
    logic pempty_q, pempty_d;
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;
    logic ack_q, ack_d;

    logic busy;
    logic wr_acc;
    logic rd_acc;

    // Both sides come out of reset together, so one countdown serves wr and rd busy.
    assign busy   = (busy_cnt_q != 4'd0);
    // Acceptance uses the registered flags: a read in the same cycle never frees room for a write.
    assign wr_acc = wr_en && !full_q  && !busy;
    assign rd_acc = rd_en && !empty_q && !busy;

    // Next-state pointers, occupancy, flags and one-cycle status pulses.
    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        busy_cnt_d = busy_cnt_q;
        if (wr_acc) wptr_d = wptr_q + PW'(1);
        if (rd_acc) rptr_d = rptr_q + PW'(1);
        if (busy)   busy_cnt_d = busy_cnt_q - 4'd1;
        count_d  = COUNT_WIDTH'(wptr_d - rptr_d);
        full_d   = (count_d == FULL_C);
        afull_d  = (count_d >= AFULL_C);
        pfull_d  = (count_d >= PFULL_C);
        empty_d  = (count_d == '0);
        aempty_d = (count_d <= ONE_C);
        pempty_d = (count_d <= PEMPTY_C);
        ovf_d    = wr_en && full_q  && !busy;
        unf_d    = rd_en && empty_q && !busy;
        ack_d    = wr_acc;
    end

    // Control state with synchronous reset; reset reloads the busy countdown.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            busy_cnt_q <= BUSY_C;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            pfull_q    <= 1'b0;
            empty_q    <= 1'b1;
            aempty_q   <= 1'b1;
            pempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            busy_cnt_q <= busy_cnt_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            pfull_q    <= pfull_d;
            empty_q    <= empty_d;
            aempty_q   <= aempty_d;
            pempty_q   <= pempty_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            ack_q      <= ack_d;
        end
    end

    // Storage array: written on accepted writes only, never reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

    // Head word falls through combinationally from the read pointer.
    assign dout          = mem_q[rptr_q[AW-1:0]];

    // Full-side flags hold their reset value until busy drops.
    assign full          = busy ? FULL_RST : full_q;
    assign almost_full   = busy ? FULL_RST : afull_q;
    assign prog_full     = busy ? FULL_RST : pfull_q;
    assign empty         = empty_q;
    assign almost_empty  = aempty_q;
    assign prog_empty    = pempty_q;
    assign data_valid    = !empty_q;
    assign wr_data_count = count_q;
    assign rd_data_count = count_q;
    assign overflow      = ovf_q;
    assign underflow     = unf_q;
    assign wr_ack        = ack_q;
    assign wr_rst_busy   = busy;
    assign rd_rst_busy   = busy;

endmodule

// File: tb/tb_fwft_fifo_sync.sv
// Scoreboard bench for fwft_fifo_sync: directed stimulus, expected data/status queued.
// Inputs change 1 time unit after a rising edge; the monitor samples on the falling edge.
// A popped word is checked whenever the DUT presents a readable head while rd_en is high.
module tb_fwft_fifo_sync;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en, rd_en;
    logic [31:0] din, dout;
    logic        full, almost_full, prog_full, overflow, wr_ack, wr_rst_busy;
    logic        empty, almost_empty, prog_empty, underflow, data_valid, rd_rst_busy;
    logic [4:0]  wr_data_count, rd_data_count;

    always #5 clk = ~clk;

    fwft_fifo_sync dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .din(din), .full(full), .almost_full(almost_full),
        .prog_full(prog_full), .wr_data_count(wr_data_count), .overflow(overflow),
        .wr_ack(wr_ack), .wr_rst_busy(wr_rst_busy),
        .rd_en(rd_en), .dout(dout), .empty(empty), .almost_empty(almost_empty),
        .prog_empty(prog_empty), .rd_data_count(rd_data_count), .underflow(underflow),
        .data_valid(data_valid), .rd_rst_busy(rd_rst_busy)
    );

    typedef struct packed {
        logic       empty, dv, aempty, pempty, full, afull, pfull;
        logic       ovf, unf, ack, wbusy, rbusy;
        logic [4:0] wcnt, rcnt;
    } st_t;

    typedef struct {
        string       name;
        st_t         st;
        bit          dchk;
        logic [31:0] d;
    } chk_t;

    logic [31:0] exp_q[$];
    chk_t        chk_q[$];
    bit          done = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Expected status for a settled, out-of-reset FIFO holding n words (depth 16, thresholds 11/5).
    function automatic st_t ex(input int n);
        st_t s;
        s.empty  = (n == 0);
        s.dv     = (n != 0);
        s.aempty = (n <= 1);
        s.pempty = (n <= 5);
        s.full   = (n == 16);
        s.afull  = (n >= 15);
        s.pfull  = (n >= 11);
        s.ovf    = 1'b0;
        s.unf    = 1'b0;
        s.ack    = 1'b0;
        s.wbusy  = 1'b0;
        s.rbusy  = 1'b0;
        s.wcnt   = 5'(n);
        s.rcnt   = 5'(n);
        return s;
    endfunction

    // Expected status while reset or reset-busy (full-side flags forced to 1).
    function automatic st_t st_rst();
        st_t s;
        s = ex(0);
        s.full  = 1'b1;
        s.afull = 1'b1;
        s.pfull = 1'b1;
        s.wbusy = 1'b1;
        s.rbusy = 1'b1;
        return s;
    endfunction

    function automatic st_t with_ack(input st_t s);
        st_t r;
        r = s;
        r.ack = 1'b1;
        return r;
    endfunction

    // Present inputs for the next rising edge, then return just after that edge.
    task automatic cyc(input logic w, input logic [31:0] d, input logic r);
        wr_en = w;
        din   = d;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input st_t s);
        chk_t c;
        c.name = name; c.st = s; c.dchk = 1'b0; c.d = '0;
        chk_q.push_back(c);
    endtask

    task automatic chkd(input string name, input st_t s, input logic [31:0] d);
        chk_t c;
        c.name = name; c.st = s; c.dchk = 1'b1; c.d = d;
        chk_q.push_back(c);
    endtask

    // Accepted write: the word is expected to come out later in order.
    task automatic wr(input logic [31:0] d);
        exp_q.push_back(d);
        cyc(1'b1, d, 1'b0);
    endtask

    // Monitor: status comparisons, data pops, end-of-run summary.
    always @(negedge clk) begin
        st_t  act;
        chk_t c;
        act = {empty, data_valid, almost_empty, prog_empty, full, almost_full, prog_full,
               overflow, underflow, wr_ack, wr_rst_busy, rd_rst_busy, wr_data_count, rd_data_count};
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            n_tests++;
            if (act !== c.st) begin
                n_fail++;
                $display("FAIL %s: status got %b want %b", c.name, act, c.st);
            end
            if (c.dchk) begin
                n_tests++;
                if (dout !== c.d) begin
                    n_fail++;
                    $display("FAIL %s_dout: got %h want %h", c.name, dout, c.d);
                end
            end
        end
        if (rd_en === 1'b1 && empty === 1'b0 && rd_rst_busy === 1'b0) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop: got %h want no word", dout);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (dout !== e) begin
                    n_fail++;
                    $display("FAIL pop: got %h want %h", dout, e);
                end
            end
        end
        if (done) begin
            n_tests++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL leftover: got %0d words unread want 0", exp_q.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st_t s;
        rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        @(negedge clk);

        // 1. reset and busy window; requests during busy are ignored
        cyc(1'b0, 32'h0, 1'b0);
        chk("reset", st_rst());
        rst_n = 1'b1;
        cyc(1'b1, 32'hFFFF_0001, 1'b1);
        cyc(1'b1, 32'hFFFF_0002, 1'b1);
        cyc(1'b1, 32'hFFFF_0003, 1'b1);
        chk("busy3", st_rst());
        cyc(1'b1, 32'hFFFF_0004, 1'b1);
        chk("busy_drop", ex(0));

        // 2. fall-through and read-back
        wr(32'hA1);
        chkd("wr1", with_ack(ex(1)), 32'hA1);
        wr(32'hA2);
        wr(32'hA3);
        chk("wr3", with_ack(ex(3)));
        cyc(1'b0, 32'h0, 1'b1);
        chkd("rd1", ex(2), 32'hA2);
        cyc(1'b0, 32'h0, 1'b1);
        chkd("rd2", ex(1), 32'hA3);
        cyc(1'b0, 32'h0, 1'b1);
        chk("rd3", ex(0));

        // 3. fill to full, overflow, read does not make room for a same-cycle write
        for (int i = 0; i < 16; i++) begin
            wr(32'h100 + 32'(i));
            chk($sformatf("fill%0d", i + 1), with_ack(ex(i + 1)));
        end
        cyc(1'b1, 32'hDEAD, 1'b0);
        s = ex(16); s.ovf = 1'b1;
        chk("ovf", s);
        cyc(1'b1, 32'hBEEF, 1'b1);
        s = ex(15); s.ovf = 1'b1;
        chk("ovf_rd", s);
        for (int i = 0; i < 15; i++) cyc(1'b0, 32'h0, 1'b1);
        chk("drain", ex(0));

        // 4. underflow, and write accepted while a read underflows on empty
        cyc(1'b0, 32'h0, 1'b1);
        s = ex(0); s.unf = 1'b1;
        chk("unf", s);
        exp_q.push_back(32'hC4);
        cyc(1'b1, 32'hC4, 1'b1);
        s = ex(1); s.unf = 1'b1; s.ack = 1'b1;
        chk("unf_wr", s);
        cyc(1'b0, 32'h0, 1'b1);
        chk("unf_rd", ex(0));

        // 5. steady write+read at count 8 across pointer wrap
        for (int i = 0; i < 8; i++) wr(32'h500 + 32'(i));
        chk("pre8", with_ack(ex(8)));
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(32'h600 + 32'(i));
            cyc(1'b1, 32'h600 + 32'(i), 1'b1);
            chk($sformatf("steady%0d", i), with_ack(ex(8)));
        end
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0, 1'b1);
        chk("steady_drain", ex(0));

        // 6. mid-operation reset discards stored words
        for (int i = 0; i < 5; i++) wr(32'h700 + 32'(i));
        chk("pre_rst5", with_ack(ex(5)));
        rst_n = 1'b0;
        exp_q.delete();
        cyc(1'b0, 32'h0, 1'b0);
        chk("rst2", st_rst());
        rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("rst2_busy", st_rst());
        cyc(1'b0, 32'h0, 1'b0);
        chk("rst2_idle", ex(0));
        wr(32'h800);
        chkd("post_rst_wr", with_ack(ex(1)), 32'h800);
        cyc(1'b0, 32'h0, 1'b1);
        chk("post_rst_rd", ex(0));

        cyc(1'b0, 32'h0, 1'b0);
        done = 1'b1;
    end

endmodule
